// File: rtl/reg_pkg.sv
// Shared defaults and the byte-lane merge used by both the entry update and the read bypass.
package reg_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/reg_entry.sv
// One register-file entry: WIDTH bits with per-byte write enables plus a pending flag.
module reg_entry
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int SW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SW-1:0]    wstrb,
  input  logic             pend_set,
  input  logic             pend_clr,
  output logic [WIDTH-1:0] q,
  output logic             pend
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             pend_d, pend_q;

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < SW; i++) begin
      data_d[8*i +: 8] = merge_byte(data_q[8*i +: 8], wdata[8*i +: 8], wr_en & wstrb[i]);
    end
    // a new producer marking the entry outranks the write that retires the old one
    if (pend_set)      pend_d = 1'b1;
    else if (pend_clr) pend_d = 1'b0;
    else               pend_d = pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign q    = data_q;
  assign pend = pend_q;

endmodule

// File: rtl/reg_file_bank.sv
// Two-read, one-write register file with byte strobes, pending-write scoreboard and optional bypass.
module reg_file_bank
  import reg_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SW-1:0]    wstrb,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  output logic             pend_a,
  output logic             pend_b
);

  // slots beyond DEPTH exist only so any address can index the arrays safely
  localparam int NSLOT = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] entry_data [NSLOT];
  logic             entry_pend [NSLOT];
  logic             ent_we     [NSLOT];
  logic             ent_ps     [NSLOT];
  logic             wr_ok, ps_ok;
  logic [AW-1:0]    rd_addr    [2];
  logic [WIDTH-1:0] rd_data    [2];
  logic             rd_pend    [2];

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    wr_ok = we & addr_ok(waddr);
    ps_ok = pend_set & addr_ok(pend_addr);
    for (int i = 0; i < NSLOT; i++) begin
      ent_we[i] = wr_ok && (waddr == AW'(i));
      ent_ps[i] = ps_ok && (pend_addr == AW'(i));
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < DEPTH) begin : g_ent
      reg_entry #(.WIDTH(WIDTH)) u_entry (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (ent_we[g]),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .pend_set (ent_ps[g]),
        .pend_clr (ent_we[g]),
        .q        (entry_data[g]),
        .pend     (entry_pend[g])
      );
    end else begin : g_none
      assign entry_data[g] = '0;
      assign entry_pend[g] = 1'b0;
    end
  end

  assign rd_addr[0] = raddr_a;
  assign rd_addr[1] = raddr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_pend[p] = 1'b0;
      if (addr_ok(rd_addr[p])) begin
        rd_data[p] = entry_data[rd_addr[p]];
        rd_pend[p] = entry_pend[rd_addr[p]];
        if ((BYPASS != 0) && wr_ok && (rd_addr[p] == waddr)) begin
          for (int i = 0; i < SW; i++) begin
            rd_data[p][8*i +: 8] = merge_byte(entry_data[rd_addr[p]][8*i +: 8],
                                              wdata[8*i +: 8], wstrb[i]);
          end
          if (!(ps_ok && (pend_addr == waddr))) rd_pend[p] = 1'b0;
        end
      end
    end
  end

  assign rdata_a = rd_data[0];
  assign rdata_b = rd_data[1];
  assign pend_a  = rd_pend[0];
  assign pend_b  = rd_pend[1];

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed checks of reg_file_bank: default build plus a DEPTH=20, BYPASS=0 build.
module tb_reg_file_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance (DEPTH=32, BYPASS=1, ZERO_REG=1)
  logic        we = 0, pend_set = 0;
  logic [4:0]  waddr = 0, raddr_a = 0, raddr_b = 0, pend_addr = 0;
  logic [31:0] wdata = 0, rdata_a, rdata_b;
  logic [3:0]  wstrb = 0;
  logic        pend_a, pend_b;

  reg_file_bank u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(pend_a), .pend_b(pend_b)
  );

  // small instance (DEPTH=20, BYPASS=0)
  logic        we2 = 0, pend_set2 = 0;
  logic [4:0]  waddr2 = 0, raddr_a2 = 0, raddr_b2 = 0, pend_addr2 = 0;
  logic [31:0] wdata2 = 0, rdata_a2, rdata_b2;
  logic [3:0]  wstrb2 = 0;
  logic        pend_a2, pend_b2;

  reg_file_bank #(.DEPTH(20), .BYPASS(0)) u_d20 (
    .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2), .wstrb(wstrb2),
    .raddr_a(raddr_a2), .raddr_b(raddr_b2), .rdata_a(rdata_a2), .rdata_b(rdata_b2),
    .pend_set(pend_set2), .pend_addr(pend_addr2), .pend_a(pend_a2), .pend_b(pend_b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step();
    step();
    rst = 0;
    raddr_a = 5; raddr_b = 7;
    #1;
    chk("rst_data5", rdata_a, 32'h0);
    chk("rst_pend5", {31'b0, pend_a}, 32'h0);

    // full write to 5, bypass visible before the edge
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    #1;
    chk("wr5_bypass", rdata_a, 32'hDEADBEEF);
    step();
    we = 0;
    #1;
    chk("wr5_stored", rdata_a, 32'hDEADBEEF);

    // partial write, lanes 0 and 2
    we = 1; wdata = 32'h11223344; wstrb = 4'h5; raddr_b = 5;
    #1;
    chk("strb5_bypass", rdata_a, 32'hDE22BE44);
    step();
    we = 0;
    #1;
    chk("strb5_stored", rdata_a, 32'hDE22BE44);
    chk("same_addr_ab", rdata_b, 32'hDE22BE44);

    // entry 0 is hardwired zero
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    pend_set = 1; pend_addr = 0; raddr_a = 0;
    #1;
    chk("zero_data_now", rdata_a, 32'h0);
    chk("zero_pend_now", {31'b0, pend_a}, 32'h0);
    step();
    we = 0; pend_set = 0;
    #1;
    chk("zero_data_after", rdata_a, 32'h0);
    chk("zero_pend_after", {31'b0, pend_a}, 32'h0);

    // pending scoreboard on 7
    raddr_b = 7; pend_set = 1; pend_addr = 7;
    #1;
    chk("pend7_before", {31'b0, pend_b}, 32'h0);
    step();
    pend_set = 0;
    #1;
    chk("pend7_set", {31'b0, pend_b}, 32'h1);
    we = 1; waddr = 7; wdata = 32'h000000A5; wstrb = 4'hF; pend_set = 1; pend_addr = 7;
    #1;
    chk("pend7_setclr_now", {31'b0, pend_b}, 32'h1);
    step();
    we = 0; pend_set = 0;
    #1;
    chk("pend7_setclr_after", {31'b0, pend_b}, 32'h1);
    chk("data7", rdata_b, 32'h000000A5);
    we = 1; waddr = 7; wdata = 32'h0000005A;
    #1;
    chk("pend7_clr_bypass", {31'b0, pend_b}, 32'h0);
    step();
    we = 0;
    #1;
    chk("pend7_clr_after", {31'b0, pend_b}, 32'h0);
    chk("data7_b", rdata_b, 32'h0000005A);

    // zero-strobe write clears pend but keeps data
    raddr_a = 9;
    we = 1; waddr = 9; wdata = 32'h00000055; wstrb = 4'hF; pend_set = 1; pend_addr = 9;
    step();
    we = 1; wdata = 32'hFFFFFFFF; wstrb = 4'h0; pend_set = 0;
    #1;
    chk("nostrb_bypass", rdata_a, 32'h00000055);
    step();
    we = 0;
    #1;
    chk("nostrb_data", rdata_a, 32'h00000055);
    chk("nostrb_pend", {31'b0, pend_a}, 32'h0);

    // reset beats a concurrent write and pend_set; reads stay live until the edge
    pend_set = 1; pend_addr = 11;
    step();
    pend_set = 0;
    rst = 1; we = 1; waddr = 3; wdata = 32'h12345678; wstrb = 4'hF;
    pend_set = 1; pend_addr = 11; raddr_a = 5; raddr_b = 11;
    #1;
    chk("prerst_data5", rdata_a, 32'hDE22BE44);
    chk("prerst_pend11", {31'b0, pend_b}, 32'h1);
    step();
    rst = 0; we = 0; pend_set = 0;
    raddr_a = 3;
    #1;
    chk("postrst_data3", rdata_a, 32'h0);
    raddr_a = 5;
    #1;
    chk("postrst_data5", rdata_a, 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      #1;
      chk($sformatf("postrst_pend%0d", i), {31'b0, pend_a}, 32'h0);
    end

    // DEPTH=20 / BYPASS=0 instance
    we2 = 1; waddr2 = 19; wdata2 = 32'h00001234; wstrb2 = 4'hF; raddr_a2 = 19;
    #1;
    chk("d20_nobypass", rdata_a2, 32'h0);
    step();
    we2 = 0;
    #1;
    chk("d20_data19", rdata_a2, 32'h00001234);
    we2 = 1; waddr2 = 25; wdata2 = 32'hFFFFFFFF; pend_set2 = 1; pend_addr2 = 25; raddr_b2 = 25;
    step();
    we2 = 0; pend_set2 = 0;
    #1;
    chk("d20_read25", rdata_b2, 32'h0);
    chk("d20_pend25", {31'b0, pend_b2}, 32'h0);
    chk("d20_data19_kept", rdata_a2, 32'h00001234);
    raddr_a2 = 9;
    #1;
    chk("d20_data9", rdata_a2, 32'h0);
    chk("d20_pend9", {31'b0, pend_a2}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
